// File: rtl/ux607_uart_icb_arb.sv
// Two-master ICB arbiter in front of a single UART ICB target: round-robin command
// grant held while stalled, in-order owner tags route each response to its issuer.
module ux607_uart_icb_arb #(
  parameter int AW         = 32,
  parameter int OUTS_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,

  input  logic          m0_icb_cmd_valid,
  output logic          m0_icb_cmd_ready,
  input  logic [AW-1:0] m0_icb_cmd_addr,
  input  logic          m0_icb_cmd_read,
  input  logic [31:0]   m0_icb_cmd_wdata,
  output logic          m0_icb_rsp_valid,
  input  logic          m0_icb_rsp_ready,
  output logic [31:0]   m0_icb_rsp_rdata,

  input  logic          m1_icb_cmd_valid,
  output logic          m1_icb_cmd_ready,
  input  logic [AW-1:0] m1_icb_cmd_addr,
  input  logic          m1_icb_cmd_read,
  input  logic [31:0]   m1_icb_cmd_wdata,
  output logic          m1_icb_rsp_valid,
  input  logic          m1_icb_rsp_ready,
  output logic [31:0]   m1_icb_rsp_rdata,

  output logic          o_icb_cmd_valid,
  input  logic          o_icb_cmd_ready,
  output logic [AW-1:0] o_icb_cmd_addr,
  output logic          o_icb_cmd_read,
  output logic [31:0]   o_icb_cmd_wdata,
  input  logic          o_icb_rsp_valid,
  output logic          o_icb_rsp_ready,
  input  logic [31:0]   o_icb_rsp_rdata,

  output logic          arb_busy
);

  localparam int PW = (OUTS_DEPTH > 1) ? $clog2(OUTS_DEPTH) : 1;
  localparam int CW = $clog2(OUTS_DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(OUTS_DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(OUTS_DEPTH - 1);

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == LAST_PTR) begin
      return {PW{1'b0}};
    end else begin
      return p + PW'(1);
    end
  endfunction

  logic          last_gnt_q, last_gnt_d;
  logic          lock_q, lock_d;
  logic          lock_id_q, lock_id_d;
  logic          tag_q [OUTS_DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic gnt_id_s, gnt_valid_s;
  logic fifo_full_s, fifo_empty_s;
  logic head_s;
  logic cmd_hs_s, rsp_hs_s, cmd_stall_s;

  assign fifo_full_s  = (cnt_q == FULL_CNT);
  assign fifo_empty_s = (cnt_q == {CW{1'b0}});
  assign head_s       = tag_q[rptr_q];

  // Grant selection: a stalled command keeps its owner, otherwise round-robin on ties.
  always_comb begin
    gnt_id_s    = 1'b0;
    gnt_valid_s = 1'b0;
    if (lock_q) begin
      gnt_id_s    = lock_id_q;
      gnt_valid_s = lock_id_q ? m1_icb_cmd_valid : m0_icb_cmd_valid;
    end else if (m0_icb_cmd_valid && m1_icb_cmd_valid) begin
      gnt_id_s    = ~last_gnt_q;
      gnt_valid_s = 1'b1;
    end else if (m1_icb_cmd_valid) begin
      gnt_id_s    = 1'b1;
      gnt_valid_s = 1'b1;
    end else if (m0_icb_cmd_valid) begin
      gnt_id_s    = 1'b0;
      gnt_valid_s = 1'b1;
    end else begin
      gnt_id_s    = 1'b0;
      gnt_valid_s = 1'b0;
    end
  end

  assign o_icb_cmd_valid  = gnt_valid_s & ~fifo_full_s;
  assign o_icb_cmd_addr   = gnt_id_s ? m1_icb_cmd_addr  : m0_icb_cmd_addr;
  assign o_icb_cmd_read   = gnt_id_s ? m1_icb_cmd_read  : m0_icb_cmd_read;
  assign o_icb_cmd_wdata  = gnt_id_s ? m1_icb_cmd_wdata : m0_icb_cmd_wdata;
  assign m0_icb_cmd_ready = o_icb_cmd_valid & ~gnt_id_s & o_icb_cmd_ready;
  assign m1_icb_cmd_ready = o_icb_cmd_valid &  gnt_id_s & o_icb_cmd_ready;

  assign cmd_hs_s    = o_icb_cmd_valid & o_icb_cmd_ready;
  assign cmd_stall_s = o_icb_cmd_valid & ~o_icb_cmd_ready;

  // An empty tag FIFO means any target response is spurious: never routed or accepted.
  assign m0_icb_rsp_valid = o_icb_rsp_valid & ~fifo_empty_s & ~head_s;
  assign m1_icb_rsp_valid = o_icb_rsp_valid & ~fifo_empty_s &  head_s;
  assign m0_icb_rsp_rdata = o_icb_rsp_rdata;
  assign m1_icb_rsp_rdata = o_icb_rsp_rdata;
  assign o_icb_rsp_ready  = ~fifo_empty_s & (head_s ? m1_icb_rsp_ready : m0_icb_rsp_ready);
  assign rsp_hs_s         = o_icb_rsp_valid & o_icb_rsp_ready;

  assign arb_busy = ~fifo_empty_s;

  // Next-state for grant history, stall lock and tag FIFO bookkeeping.
  always_comb begin
    last_gnt_d = last_gnt_q;
    lock_d     = lock_q;
    lock_id_d  = lock_id_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    cnt_d      = cnt_q;

    if (cmd_hs_s) begin
      last_gnt_d = gnt_id_s;
      lock_d     = 1'b0;
      wptr_d     = ptr_inc(wptr_q);
    end else if (cmd_stall_s) begin
      lock_d     = 1'b1;
      lock_id_d  = gnt_id_s;
    end else begin
      lock_d     = lock_q;
    end

    if (rsp_hs_s) begin
      rptr_d = ptr_inc(rptr_q);
    end else begin
      rptr_d = rptr_q;
    end

    case ({cmd_hs_s, rsp_hs_s})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers; tag entries are written at the write pointer on each command handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt_q <= 1'b1;
      lock_q     <= 1'b0;
      lock_id_q  <= 1'b0;
      wptr_q     <= {PW{1'b0}};
      rptr_q     <= {PW{1'b0}};
      cnt_q      <= {CW{1'b0}};
      for (int i = 0; i < OUTS_DEPTH; i++) begin
        tag_q[i] <= 1'b0;
      end
    end else begin
      last_gnt_q <= last_gnt_d;
      lock_q     <= lock_d;
      lock_id_q  <= lock_id_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      if (cmd_hs_s) begin
        tag_q[wptr_q] <= gnt_id_s;
      end
    end
  end

endmodule
